// File: rtl/prpg_pkg.sv
// Shared PRPG definitions: maximal-length tap masks for widths 3..16 and
// the feedback / zero-detect helpers used by the step logic.
package prpg_pkg;

  localparam int MIN_WIDTH = 3;
  localparam int MAX_WIDTH = 16;

  // Bit i set means state bit i feeds the XOR; entry n is a primitive polynomial of degree n.
  localparam logic [15:0] TAPS [3:16] = '{
    16'h0006,  // 3
    16'h000C,  // 4
    16'h0014,  // 5
    16'h0030,  // 6
    16'h0060,  // 7
    16'h00B8,  // 8
    16'h0110,  // 9
    16'h0240,  // 10
    16'h0500,  // 11
    16'h0829,  // 12
    16'h100D,  // 13
    16'h2015,  // 14
    16'h6000,  // 15
    16'hB400   // 16
  };

  function automatic logic feedback(input logic [15:0] state, input logic [4:0] width);
    return ^(state & TAPS[width]);
  endfunction

  function automatic logic is_zero(input logic [15:0] state);
    return (state == 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next state of the Fibonacci LFSR: shift left, feedback into
// bit 0, and recovery to SEED if the all-zero lock-up state is ever present.
module lfsr_step
  import prpg_pkg::*;
#(
  parameter int              WIDTH = 3,
  parameter logic [WIDTH-1:0] SEED = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  logic [15:0] state_ext;

  assign state_ext = 16'(state_i);

  always_comb begin
    next_o = {state_i[WIDTH-2:0], feedback(state_ext, 5'(WIDTH))};
    // All-zero is a fixed point of the XOR feedback, so it can only be left by reseeding.
    if (is_zero(state_ext)) begin
      next_o = SEED;
    end
  end

endmodule

// File: rtl/prpg_lfsr.sv
// Maximal-length PRPG: registered LFSR state advancing every clock, with a
// synchronous active-high set that loads SEED and overrides stepping.
module prpg_lfsr
  import prpg_pkg::*;
#(
  parameter int              WIDTH = 3,
  parameter logic [WIDTH-1:0] SEED = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             set,
  output logic [WIDTH-1:0] Q1
);

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("prpg_lfsr: WIDTH %0d outside supported range 3..16", WIDTH);
    end
    if (SEED == '0) begin : g_bad_seed
      $error("prpg_lfsr: SEED must be non-zero");
    end
  endgenerate

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  lfsr_step #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_step (
    .state_i (q_q),
    .next_o  (q_d)
  );

  always_ff @(posedge clk) begin
    if (set) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q1 = q_q;

endmodule

// File: tb/tb_prpg_lfsr.sv
// Directed bench for prpg_lfsr at WIDTH 3, 4 (seed 0001) and 8, checked
// against an independent reference model through an expected-value queue.
module tb_prpg_lfsr;

  logic       clk;
  logic       set3, set4, set8;
  logic [2:0] q3;
  logic [3:0] q4;
  logic [7:0] q8;

  prpg_lfsr #(.WIDTH(3)) u3 (.clk(clk), .set(set3), .Q1(q3));
  prpg_lfsr #(.WIDTH(4), .SEED(4'b0001)) u4 (.clk(clk), .set(set4), .Q1(q4));
  prpg_lfsr #(.WIDTH(8)) u8 (.clk(clk), .set(set8), .Q1(q8));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [2:0] e3;
    logic [3:0] e4;
    logic [7:0] e8;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] m3 = '0;
  logic [3:0] m4 = '0;
  logic [7:0] m8 = '0;
  logic [2:0] o3;
  logic [3:0] o4;
  logic [7:0] o8;

  // Reference polynomials: x^3+x^2+1, x^4+x^3+1, x^8+x^6+x^5+x^4+1.
  function automatic logic [2:0] ref3(input logic [2:0] s, input logic rst);
    if (rst || s == 3'b000) return 3'b111;
    return {s[1:0], s[2] ^ s[1]};
  endfunction

  function automatic logic [3:0] ref4(input logic [3:0] s, input logic rst);
    if (rst || s == 4'b0000) return 4'b0001;
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  function automatic logic [7:0] ref8(input logic [7:0] s, input logic rst);
    if (rst || s == 8'h00) return 8'hFF;
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict, push, clock, pop and compare all three instances.
  task automatic cycle();
    exp_t e;
    m3 = ref3(m3, set3);
    m4 = ref4(m4, set4);
    m8 = ref8(m8, set8);
    sb.push_back('{e3: m3, e4: m4, e8: m8});
    @(posedge clk);
    #1;
    o3 = q3;
    o4 = q4;
    o8 = q8;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk("w3_model", 16'(o3), 16'(e.e3));
      chk("w4_model", 16'(o4), 16'(e.e4));
      chk("w8_model", 16'(o8), 16'(e.e8));
    end
  endtask

  initial begin
    logic [7:0]  seen3;
    logic [15:0] seen4;
    int          last111;
    int          first_ret;
    int          early4;

    set3 = 1'b1;
    set4 = 1'b1;
    set8 = 1'b1;

    // Reset state.
    cycle();
    chk("reset_w3", 16'(o3), 16'h0007);
    chk("reset_w4", 16'(o4), 16'h0001);
    chk("reset_w8", 16'(o8), 16'h00FF);
    cycle();
    chk("reset_hold_w3", 16'(o3), 16'h0007);
    set3 = 1'b0;
    set4 = 1'b0;
    set8 = 1'b0;

    // First steps after release.
    cycle(); chk("w3_step1", 16'(o3), 16'b110);
    cycle(); chk("w3_step2", 16'(o3), 16'b100);
    cycle(); chk("w3_step3", 16'(o3), 16'b001);

    // Free run: period 7, every non-zero value, never zero.
    seen3   = '0;
    last111 = -1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      seen3[o3] = 1'b1;
      if (o3 === 3'b111) begin
        if (last111 >= 0) chk("w3_period", 16'(i - last111), 16'd7);
        last111 = i;
      end
    end
    chk("w3_cover", 16'(seen3), 16'h00FE);

    // Mid-sequence set while at 010.
    for (int i = 0; i < 10 && o3 !== 3'b010; i++) cycle();
    chk("w3_find_010", 16'(o3), 16'b010);
    set3 = 1'b1;
    cycle(); chk("w3_set_mid", 16'(o3), 16'b111);
    set3 = 1'b0;
    cycle(); chk("w3_restart", 16'(o3), 16'b110);

    // Lock-up recovery from a deposited all-zero state.
    u3.q_q = 3'b000;
    m3     = 3'b000;
    #1;
    chk("w3_forced_zero", 16'(q3), 16'h0000);
    cycle(); chk("w3_lockup", 16'(o3), 16'b111);
    cycle(); chk("w3_after_lockup", 16'(o3), 16'b110);

    // WIDTH=4, SEED=0001: period 15, each non-zero value once.
    set4 = 1'b1;
    cycle(); chk("w4_seed", 16'(o4), 16'h0001);
    set4   = 1'b0;
    seen4  = '0;
    early4 = 0;
    for (int i = 1; i <= 15; i++) begin
      cycle();
      seen4[o4] = 1'b1;
      if (i < 15 && o4 === 4'b0001) early4++;
    end
    chk("w4_cover", seen4, 16'hFFFE);
    chk("w4_period", 16'(o4), 16'h0001);
    chk("w4_early_return", 16'(early4), 16'd0);

    // WIDTH=8: set held for 10 cycles, then a full 255-step period.
    set8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("w8_hold", 16'(o8), 16'h00FF);
    end
    set8      = 1'b0;
    first_ret = 0;
    for (int i = 1; i <= 255; i++) begin
      cycle();
      if (o8 === 8'hFF && first_ret == 0) first_ret = i;
    end
    chk("w8_period", 16'(first_ret), 16'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
